// File: rtl/mem_stage_unit.sv
// MIPS32 memory stage: BRAM-style data memory with one-cycle registered loads,
// sub-word stores/loads, load-buffer routing, error capture and access counters.
module mem_stage_unit #(
    parameter string MEM_INIT = "none_2.mem",
    parameter int    DEPTH    = 1024,
    parameter int    NUM_BUF  = 2,
    parameter int    BUF_AW   = 3,
    parameter int    CNT_W    = 16
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [31:0]             EX_MEM_ALUResult,
    input  logic [31:0]             EX_MEM_rt_val,
    input  logic                    EX_MEM_MemWrite,
    input  logic                    EX_MEM_MemRead,
    input  logic                    EX_MEM_HalfControl,
    input  logic                    EX_MEM_ByteControl,
    input  logic                    EX_MEM_SignExt,
    input  logic [NUM_BUF-1:0]      EX_MEM_load_buff,
    output logic [BUF_AW-1:0]       buf_val_addr,
    input  logic [NUM_BUF*32-1:0]   buf_val_select,
    input  logic [31:0]             MEM_AddrB,
    output logic [31:0]             MEM_ReadData_A,
    output logic                    MEM_ReadValid,
    output logic [31:0]             MEM_ReadData_B,
    output logic                    MEM_Error,
    output logic [31:0]             MEM_ErrorAddr,
    output logic [CNT_W-1:0]        MEM_LoadCount,
    output logic [CNT_W-1:0]        MEM_StoreCount
);

    localparam int AW = $clog2(DEPTH);

    // Init image is applied by the FPGA implementation flow; port B ignores byte offset.
    localparam string unused_init = MEM_INIT;
    logic unused_addr_b_bits;
    assign unused_addr_b_bits = ^MEM_AddrB[1:0];

    logic [3:0][7:0] mem [DEPTH];

    logic [1:0]    lane;
    logic          is_byte, is_half, is_word;
    logic          buf_req, load_req, any_access;
    logic          range_err, mis_err, conflict, access_err;
    logic          do_load, do_store;
    logic [AW-1:0] a_idx, b_idx;
    logic          b_oor;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   buf_data;

    assign lane         = EX_MEM_ALUResult[1:0];
    assign is_byte      = EX_MEM_ByteControl;
    assign is_half      = EX_MEM_HalfControl & ~EX_MEM_ByteControl;
    assign is_word      = ~EX_MEM_HalfControl & ~EX_MEM_ByteControl;
    assign buf_req      = |EX_MEM_load_buff;
    assign load_req     = EX_MEM_MemRead | buf_req;
    assign any_access   = load_req | EX_MEM_MemWrite;
    assign a_idx        = EX_MEM_ALUResult[AW+1:2];
    assign b_idx        = MEM_AddrB[AW+1:2];
    assign buf_val_addr = EX_MEM_ALUResult[BUF_AW-1:0];

    assign range_err  = {2'b00, EX_MEM_ALUResult[31:2]} >= 32'(DEPTH);
    assign mis_err    = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    // A store alongside any kind of load is ambiguous and is rejected as an error.
    assign conflict   = EX_MEM_MemWrite & load_req;
    assign access_err = any_access & (conflict | (~buf_req & (range_err | mis_err)));
    assign do_load    = load_req & ~access_err;
    assign do_store   = EX_MEM_MemWrite & ~access_err & Rst_n;
    assign b_oor      = {2'b00, MEM_AddrB[31:2]} >= 32'(DEPTH);

    always_comb begin
        buf_data = '0;
        for (int k = NUM_BUF - 1; k >= 0; k--) begin
            if (EX_MEM_load_buff[k]) buf_data = buf_val_select[k*32 +: 32];
        end
    end

    always_comb begin
        be    = 4'hF;
        wdata = EX_MEM_rt_val;
        if (is_byte) begin
            be    = 4'b0001 << lane;
            wdata = {4{EX_MEM_rt_val[7:0]}};
        end else if (is_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{EX_MEM_rt_val[15:0]}};
        end
    end

    logic [31:0] a_word_q;

    always_ff @(posedge Clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[a_idx][b] <= wdata[b*8 +: 8];
            end
        end
        a_word_q <= mem[a_idx];
    end

    // Nonblocking read gives read-first behaviour against a same-edge store.
    always_ff @(posedge Clk) begin
        if (!Rst_n)     MEM_ReadData_B <= '0;
        else if (b_oor) MEM_ReadData_B <= '0;
        else            MEM_ReadData_B <= mem[b_idx];
    end

    logic        ld_valid_q, ld_zero_q, ld_buf_q, byte_q, half_q, sext_q;
    logic [1:0]  lane_q;
    logic [31:0] buf_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ld_valid_q <= 1'b0;
            ld_zero_q  <= 1'b0;
            ld_buf_q   <= 1'b0;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            sext_q     <= 1'b0;
            lane_q     <= 2'b00;
            buf_q      <= '0;
        end else begin
            ld_valid_q <= load_req;
            ld_zero_q  <= access_err;
            ld_buf_q   <= buf_req;
            byte_q     <= is_byte;
            half_q     <= is_half;
            sext_q     <= EX_MEM_SignExt;
            lane_q     <= lane;
            buf_q      <= buf_data;
        end
    end

    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_fmt;

    always_comb begin
        lane8  = a_word_q[{lane_q, 3'b000} +: 8];
        lane16 = lane_q[1] ? a_word_q[31:16] : a_word_q[15:0];
        if (ld_zero_q)     load_fmt = '0;
        else if (ld_buf_q) load_fmt = buf_q;
        else if (byte_q)   load_fmt = {{24{sext_q & lane8[7]}}, lane8};
        else if (half_q)   load_fmt = {{16{sext_q & lane16[15]}}, lane16};
        else               load_fmt = a_word_q;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            MEM_ReadData_A <= '0;
            MEM_ReadValid  <= 1'b0;
        end else begin
            MEM_ReadData_A <= ld_valid_q ? load_fmt : '0;
            MEM_ReadValid  <= ld_valid_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            MEM_Error      <= 1'b0;
            MEM_ErrorAddr  <= '0;
            MEM_LoadCount  <= '0;
            MEM_StoreCount <= '0;
        end else begin
            if (access_err) begin
                MEM_Error <= 1'b1;
                if (!MEM_Error) MEM_ErrorAddr <= EX_MEM_ALUResult;
            end
            if (do_load && (MEM_LoadCount != '1))
                MEM_LoadCount <= MEM_LoadCount + 1'b1;
            if (do_store && (MEM_StoreCount != '1))
                MEM_StoreCount <= MEM_StoreCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: load results are checked by a monitor
// against an expected queue; state outputs are checked at fixed points.
module tb_mem_stage_unit;

    localparam int DEPTH   = 64;
    localparam int NUM_BUF = 4;
    localparam int BUF_AW  = 3;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic [31:0]           alu;
    logic [31:0]           rt_val;
    logic                  mem_write;
    logic                  mem_read;
    logic                  half_ctl;
    logic                  byte_ctl;
    logic                  sign_ext;
    logic [NUM_BUF-1:0]    load_buff;
    logic [BUF_AW-1:0]     buf_val_addr;
    logic [NUM_BUF*32-1:0] buf_val_select;
    logic [31:0]           addr_b;
    logic [31:0]           rdata_a;
    logic                  rvalid;
    logic [31:0]           rdata_b;
    logic                  err;
    logic [31:0]           err_addr;
    logic [CNT_W-1:0]      ld_cnt;
    logic [CNT_W-1:0]      st_cnt;

    mem_stage_unit #(
        .MEM_INIT("none_2.mem"), .DEPTH(DEPTH), .NUM_BUF(NUM_BUF),
        .BUF_AW(BUF_AW), .CNT_W(CNT_W)
    ) dut (
        .Clk(clk), .Rst_n(rst_n),
        .EX_MEM_ALUResult(alu), .EX_MEM_rt_val(rt_val),
        .EX_MEM_MemWrite(mem_write), .EX_MEM_MemRead(mem_read),
        .EX_MEM_HalfControl(half_ctl), .EX_MEM_ByteControl(byte_ctl),
        .EX_MEM_SignExt(sign_ext), .EX_MEM_load_buff(load_buff),
        .buf_val_addr(buf_val_addr), .buf_val_select(buf_val_select),
        .MEM_AddrB(addr_b), .MEM_ReadData_A(rdata_a), .MEM_ReadValid(rvalid),
        .MEM_ReadData_B(rdata_b), .MEM_Error(err), .MEM_ErrorAddr(err_addr),
        .MEM_LoadCount(ld_cnt), .MEM_StoreCount(st_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          exp_ld = 0;
    int          exp_st = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // driver tasks: inputs change on the falling edge
    task automatic set_size(input int sz);
        byte_ctl = (sz == 0);
        half_ctl = (sz == 1);
    endtask

    task automatic idle();
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load_buff = '0;
        byte_ctl  = 1'b0;
        half_ctl  = 1'b0;
        sign_ext  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input int sz, input bit ok);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b1;
        load_buff = '0;
        alu       = a;
        rt_val    = d;
        set_size(sz);
        if (ok) exp_st = sat_inc(exp_st);
    endtask

    task automatic load(input logic [31:0] a, input int sz, input bit sx,
                        input logic [31:0] exp, input bit ok);
        @(negedge clk);
        mem_read  = 1'b1;
        mem_write = 1'b0;
        load_buff = '0;
        alu       = a;
        sign_ext  = sx;
        set_size(sz);
        exp_q.push_back(exp);
        if (ok) exp_ld = sat_inc(exp_ld);
    endtask

    task automatic buf_load(input logic [NUM_BUF-1:0] sel, input logic [31:0] a,
                            input logic [31:0] exp);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load_buff = sel;
        alu       = a;
        set_size(2);
        exp_q.push_back(exp);
        exp_ld = sat_inc(exp_ld);
    endtask

    // scoreboard: every valid load result must match the head of exp_q
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) check("spurious_valid", {31'd0, rvalid}, 32'd0);
                else                   check("load_data", rdata_a, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        mem_read       = 1'b1;
        mem_write      = 1'b0;
        alu            = 32'h10;
        rt_val         = '0;
        half_ctl       = 1'b0;
        byte_ctl       = 1'b0;
        sign_ext       = 1'b0;
        load_buff      = '0;
        addr_b         = '0;
        buf_val_select = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

        // reset held two cycles with a read pending
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_valid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_ld_cnt", 32'(ld_cnt), 32'd0);
        check("rst_st_cnt", 32'(st_cnt), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        check("rst_drop_valid", {31'd0, rvalid}, 32'd0);

        // word store, byte merge, sub-word loads
        store(32'h10, 32'hDEADBEEF, 2, 1'b1);
        store(32'h11, 32'h0000005A, 0, 1'b1);
        load(32'h10, 2, 1'b0, 32'hDEAD5AEF, 1'b1);
        load(32'h13, 0, 1'b1, 32'hFFFFFFDE, 1'b1);
        load(32'h13, 0, 1'b0, 32'h000000DE, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("cnt_ld_basic", 32'(ld_cnt), 32'(exp_ld));
        check("cnt_st_basic", 32'(st_cnt), 32'(exp_st));

        // half store and exact one-cycle latency
        store(32'h22, 32'h12348001, 1, 1'b1);
        load(32'h22, 1, 1'b1, 32'hFFFF8001, 1'b1);
        @(posedge clk);
        #1;
        check("lat_edge_n_valid", {31'd0, rvalid}, 32'd0);
        idle();
        @(posedge clk);
        #1;
        check("lat_edge_n1_valid", {31'd0, rvalid}, 32'd1);
        check("lat_edge_n1_data", rdata_a, 32'hFFFF8001);
        @(posedge clk);
        #1;
        check("lat_edge_n2_valid", {31'd0, rvalid}, 32'd0);

        // store then immediate load, then back-to-back loads
        store(32'h24, 32'hCAFEF00D, 2, 1'b1);
        load(32'h24, 2, 1'b0, 32'hCAFEF00D, 1'b1);
        load(32'h22, 1, 1'b0, 32'h00008001, 1'b1);
        load(32'h12, 1, 1'b1, 32'hFFFFDEAD, 1'b1);
        idle();
        repeat (2) @(posedge clk);

        // buffer channels: lowest set channel wins, returned unextended
        buf_load(4'b1010, 32'h5, 32'h11111111);
        #1;
        check("buf_addr", {29'd0, buf_val_addr}, 32'd5);
        buf_load(4'b1000, 32'h2, 32'h33333333);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("cnt_ld_buf", 32'(ld_cnt), 32'(exp_ld));
        check("buf_no_err", {31'd0, err}, 32'd0);

        // errors: first address sticks, accesses suppressed, counters frozen
        load(32'h6, 2, 1'b0, 32'd0, 1'b0);
        store(32'(DEPTH * 4), 32'hBAD0BAD0, 2, 1'b0);
        store(32'h12, 32'hBAD1BAD1, 2, 1'b0);
        @(negedge clk);
        mem_read  = 1'b1;
        mem_write = 1'b1;
        alu       = 32'h10;
        rt_val    = 32'hBAD2BAD2;
        set_size(2);
        exp_q.push_back(32'd0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("err_flag", {31'd0, err}, 32'd1);
        check("err_addr_first", err_addr, 32'h6);
        check("err_ld_cnt", 32'(ld_cnt), 32'(exp_ld));
        check("err_st_cnt", 32'(st_cnt), 32'(exp_st));
        load(32'h10, 2, 1'b0, 32'hDEAD5AEF, 1'b1);
        idle();
        repeat (2) @(posedge clk);

        // port B: read-first on collision, byte offset ignored, out of range
        @(negedge clk);
        mem_write = 1'b1;
        alu       = 32'h10;
        rt_val    = 32'h01020304;
        set_size(2);
        addr_b    = 32'h10;
        exp_st    = sat_inc(exp_st);
        @(posedge clk);
        #1;
        check("portb_old", rdata_b, 32'hDEAD5AEF);
        idle();
        @(posedge clk);
        #1;
        check("portb_new", rdata_b, 32'h01020304);
        @(negedge clk);
        addr_b = 32'h27;
        @(posedge clk);
        #1;
        check("portb_offset", rdata_b, 32'hCAFEF00D);
        @(negedge clk);
        addr_b = 32'(DEPTH * 4);
        @(posedge clk);
        #1;
        check("portb_oor", rdata_b, 32'd0);
        check("portb_oor_no_err_addr", err_addr, 32'h6);

        // load counter saturation
        for (int i = 0; i < CNT_MAX + 4; i++) load(32'h24, 2, 1'b0, 32'hCAFEF00D, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("ld_cnt_sat", 32'(ld_cnt), 32'(CNT_MAX));
        check("st_cnt_final", 32'(st_cnt), 32'(exp_st));

        repeat (3) @(posedge clk);
        #3;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Parametrised next-generation memory-stage block for the MIPS32 pipeline.
- Holds a BRAM-style data memory with synchronous, registered reads.
- Supports byte/half/word stores with byte enables, and sign- or zero-extended sub-word loads.
- Routes loads from NUM_BUF external load-buffer channels (generalising the fixed two-channel A/B buffer select).
- Adds misalignment/range error capture and load/store access counters.

Parameters:
- MEM_INIT, "none_2.mem": $readmemh init file for data memory.
- DEPTH, 1024: data memory depth in 32-bit words; power of two.
- NUM_BUF, 2: number of load-buffer channels, 1..8.
- BUF_AW, 3: buffer entry address width, taken from EX_MEM_ALUResult[BUF_AW-1:0].
- CNT_W, 16: width of the access counters.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous reset, active-low.
- EX_MEM_ALUResult  in  32  byte address.
- EX_MEM_rt_val  in  32  store data.
- EX_MEM_MemWrite  in  1  store request.
- EX_MEM_MemRead  in  1  load request.
- EX_MEM_HalfControl  in  1  halfword access.
- EX_MEM_ByteControl  in  1  byte access; wins over Half if both are set.
- EX_MEM_SignExt  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- EX_MEM_load_buff  in  NUM_BUF  per-channel buffer-load request.
- buf_val_addr  out  BUF_AW  combinational EX_MEM_ALUResult[BUF_AW-1:0], shared by all channels.
- buf_val_select  in  NUM_BUF*32  flattened channel data; channel k occupies bits [32k+31:32k].
- MEM_AddrB  in  32  read-only port B byte address (word-aligned; bits[1:0] ignored).
- MEM_ReadData_A  out  32  load result.
- MEM_ReadValid  out  1  MEM_ReadData_A valid this cycle.
- MEM_ReadData_B  out  32  port B word, registered.
- MEM_Error  out  1  sticky access-error flag.
- MEM_ErrorAddr  out  32  address of the first error.
- MEM_LoadCount  out  CNT_W  completed loads.
- MEM_StoreCount  out  CNT_W  completed stores.

Behaviour:
- Reset (Rst_n=0 at posedge):
  - MEM_ReadData_A, MEM_ReadData_B, MEM_ErrorAddr, both counters = 0.
  - MEM_ReadValid = 0; MEM_Error = 0.
  - Memory contents are not cleared.
  - A read issued in the reset cycle is dropped: MEM_ReadValid stays 0 on the next cycle.
- Word index = ALUResult[31:2]. Range error when index >= DEPTH.
- Misalignment error:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0.
  - Not checked for buffer loads.
- Store (MemWrite=1, no error): memory written at posedge.
  - Byte enables: byte → one lane addr[1:0], data rt_val[7:0] replicated.
  - Half → lanes {addr[1],0}/+1, data rt_val[15:0].
  - Word → all four lanes.
  - Other bytes are preserved.
  - StoreCount increments.
- Load, latency 1:
  - Request at edge N.
  - MEM_ReadData_A and MEM_ReadValid=1 are presented after edge N+1, held for exactly one cycle.
  - Lane extracted per addr[1:0] and size; extended per SignExt.
  - LoadCount increments at edge N.
- Buffer load (any EX_MEM_load_buff bit set):
  - Lowest-index set channel wins.
  - buf_val_select for that channel is sampled at edge N and returned full-width (no extension).
  - Same latency and MEM_ReadValid as a memory load; no memory read occurs.
  - Counts as a load whether or not MemRead is set.
- Error on an access (load or store):
  - Access suppressed: no write, and a load returns 0 with MEM_ReadValid=1.
  - MEM_Error set.
  - MEM_ErrorAddr captured only if MEM_Error was 0 (first error wins).
  - Counters do not increment.
- MemRead and MemWrite both set: treated as an error with address = ALUResult.
- Store at edge N followed by a load of the same word at edge N+1: the load returns the new data.
- Back-to-back loads give one result per cycle.
- Port B: MEM_ReadData_B = mem[MEM_AddrB[31:2]] registered one cycle after the address; out-of-range returns 0 with no error.
- Port B / port A store collision on the same word in the same edge: port B returns old data (read-first).
- Counters saturate at all-ones (no wrap).

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles during MemRead → all outputs 0 and MEM_ReadValid stays 0 on the following cycle.
- Store word 0xDEADBEEF at 0x10, then byte store 0x5A at 0x11 → word load 0x10 returns 0xDEAD5AEF; signed byte load 0x13 returns 0xFFFFFFDE; unsigned returns 0x000000DE.
- Half store 0x8001 at 0x22; signed half load 0x22 → 0xFFFF8001, valid exactly one cycle later; store then immediate load of the same word returns the new data.
- NUM_BUF=4, load_buff=4'b1010, ALUResult=0x5, channel1=0x11111111, channel3=0x33333333 → buf_val_addr=3'b101, MEM_ReadData_A=0x11111111, LoadCount +1.
- Word load at 0x6, then store at DEPTH*4 → MEM_Error=1, MEM_ErrorAddr=0x6 (unchanged by the second error), memory unchanged, counters unchanged.
- Drive 2^CNT_W+3 loads → MEM_LoadCount saturates at all-ones; port B reading 0x10 during a store to 0x10 returns the pre-store value.
